// File: rtl/depth_test_writer.sv
// depth_test_writer: read-compare-write depth test feeding depth and framebuffer BRAMs,
// with a full-buffer clear sweep and saturating pass/reject counters.
module depth_test_writer #(
  parameter int FWIDTH = 16,
  parameter int COLOR_W = 16,
  parameter int FB_HRES = 320,
  parameter int FB_VRES = 180,
  parameter int RD_LAT = 2,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
  parameter int CNT_W = 24,
  localparam int HW = $clog2(FB_HRES),
  localparam int VW = $clog2(FB_VRES),
  localparam int ADDR_W = $clog2(FB_HRES*FB_VRES),
  localparam int NPIX = FB_HRES*FB_VRES
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [HW-1:0]            hcount_in,
  input  logic [VW-1:0]            vcount_in,
  input  logic signed [FWIDTH-1:0] z_in,
  input  logic [COLOR_W-1:0]       color_in,
  input  logic                     clear_in,
  output logic                     clear_busy_out,
  output logic [ADDR_W-1:0]        depth_addr_out,
  input  logic [FWIDTH-1:0]        depth_rd_data_in,
  output logic                     depth_wr_en_out,
  output logic [FWIDTH-1:0]        depth_wr_data_out,
  output logic [ADDR_W-1:0]        fb_addr_out,
  output logic                     fb_wr_en_out,
  output logic [COLOR_W-1:0]       fb_wr_data_out,
  output logic [CNT_W-1:0]         pass_count_out,
  output logic [CNT_W-1:0]         reject_count_out
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, CLEAR} state_t;
  localparam logic [FWIDTH-1:0] FAR_Z = {1'b0, {(FWIDTH-1){1'b1}}};
  state_t state;
  logic pend;
  logic signed [FWIDTH-1:0] z;
  logic [COLOR_W-1:0] color;
  logic [$clog2(RD_LAT+1)-1:0] wcnt;
  logic in_range, accept;
  logic [ADDR_W-1:0] pix_addr;
  assign ready_out = state == IDLE && !pend && !rst_in;
  assign accept = valid_in && ready_out && !clear_in;
  assign in_range = 32'(hcount_in) < FB_HRES && 32'(vcount_in) < FB_VRES;
  assign pix_addr = ADDR_W'(32'(vcount_in) * FB_HRES + 32'(hcount_in));
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      pend <= 1'b0;
      z <= '0;
      color <= '0;
      wcnt <= '0;
      clear_busy_out <= 1'b0;
      depth_addr_out <= '0;
      depth_wr_en_out <= 1'b0;
      depth_wr_data_out <= '0;
      fb_addr_out <= '0;
      fb_wr_en_out <= 1'b0;
      fb_wr_data_out <= '0;
      pass_count_out <= '0;
      reject_count_out <= '0;
    end else begin
      depth_wr_en_out <= 1'b0;
      depth_wr_data_out <= '0;
      fb_wr_en_out <= 1'b0;
      fb_wr_data_out <= '0;
      // a clear arriving mid-pixel waits until the pixel retires
      if (clear_in && (state == READ || state == WAIT || state == WRITE)) pend <= 1'b1;
      case (state)
        IDLE:
          if (clear_in || pend) begin
            state <= CLEAR;
            pend <= 1'b0;
            clear_busy_out <= 1'b1;
            depth_addr_out <= '0;
            fb_addr_out <= '0;
            depth_wr_en_out <= 1'b1;
            depth_wr_data_out <= FAR_Z;
            fb_wr_en_out <= 1'b1;
            fb_wr_data_out <= CLEAR_COLOR;
            pass_count_out <= '0;
            reject_count_out <= '0;
          end else if (accept && in_range) begin
            state <= READ;
            depth_addr_out <= pix_addr;
            z <= z_in;
            color <= color_in;
          end else if (accept) begin
            reject_count_out <= reject_count_out + CNT_W'(reject_count_out != '1);
          end
        READ: begin
          state <= WAIT;
          wcnt <= '0;
        end
        WAIT:
          if (32'(wcnt) == RD_LAT - 1) begin
            state <= WRITE;
            if (z < $signed(depth_rd_data_in)) begin
              depth_wr_en_out <= 1'b1;
              depth_wr_data_out <= z;
              fb_wr_en_out <= 1'b1;
              fb_addr_out <= depth_addr_out;
              fb_wr_data_out <= color;
              pass_count_out <= pass_count_out + CNT_W'(pass_count_out != '1);
            end else begin
              reject_count_out <= reject_count_out + CNT_W'(reject_count_out != '1);
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        WRITE: state <= IDLE;
        CLEAR:
          if (32'(depth_addr_out) == NPIX - 1) begin
            state <= IDLE;
            clear_busy_out <= 1'b0;
          end else begin
            depth_addr_out <= depth_addr_out + 1'b1;
            fb_addr_out <= fb_addr_out + 1'b1;
            depth_wr_en_out <= 1'b1;
            depth_wr_data_out <= FAR_Z;
            fb_wr_en_out <= 1'b1;
            fb_wr_data_out <= CLEAR_COLOR;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_depth_test_writer.sv
// tb_depth_test_writer: randomized and directed checks of depth_test_writer against a
// per-pixel depth/colour array model with an RD_LAT-cycle BRAM around the DUT.
module tb_depth_test_writer;
  localparam int HRES = 5, VRES = 3, LAT = 2, CW = 4, NPIX = HRES * VRES;
  localparam int AW = $clog2(NPIX), HW = $clog2(HRES), VW = $clog2(VRES);
  localparam logic [15:0] CC = 16'h1234;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, rst = 1, valid = 0, clear = 0;
  logic [HW-1:0] hcount = 0;
  logic [VW-1:0] vcount = 0;
  logic signed [15:0] z = 0;
  logic [15:0] color = 0, drd, dwd, fwd;
  logic ready, busy, dwe, fwe;
  logic [AW-1:0] daddr, faddr;
  logic [CW-1:0] pcnt, rcnt;
  logic [15:0] dmem [NPIX];
  logic [15:0] fmem [NPIX];
  logic [15:0] dpipe [LAT];
  logic signed [15:0] ref_d [NPIX];
  logic [15:0] ref_f [NPIX];
  int ref_p = 0, ref_r = 0, total = 0, passed = 0;

  depth_test_writer #(.FWIDTH(16), .COLOR_W(16), .FB_HRES(HRES), .FB_VRES(VRES), .RD_LAT(LAT),
    .CLEAR_COLOR(CC), .CNT_W(CW)) dut (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready), .hcount_in(hcount),
    .vcount_in(vcount), .z_in(z), .color_in(color), .clear_in(clear), .clear_busy_out(busy),
    .depth_addr_out(daddr), .depth_rd_data_in(drd), .depth_wr_en_out(dwe),
    .depth_wr_data_out(dwd), .fb_addr_out(faddr), .fb_wr_en_out(fwe), .fb_wr_data_out(fwd),
    .pass_count_out(pcnt), .reject_count_out(rcnt));

  always #5 clk = ~clk;

  // external memories: depth BRAM with LAT-cycle read pipeline, framebuffer write-only
  always @(posedge clk) begin
    if (dwe) dmem[daddr] <= dwd;
    if (fwe) fmem[faddr] <= fwd;
    dpipe[0] <= dmem[daddr];
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign drd = dpipe[LAT-1];

  function automatic int sat(input int x);
    return x >= SAT ? SAT : x + 1;
  endfunction

  task automatic sweep(input bit poke);
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1) $display("FAIL sweep_busy[%0d]: got %b want 1", i, busy); else passed++;
      total++; if ({dwe, fwe} !== 2'b11) $display("FAIL sweep_we[%0d]: got %b want 11", i, {dwe, fwe}); else passed++;
      total++; if (daddr !== AW'(i) || faddr !== AW'(i)) $display("FAIL sweep_addr[%0d]: got %0d/%0d want %0d", i, daddr, faddr, i); else passed++;
      total++; if (dwd !== 16'h7FFF || fwd !== CC) $display("FAIL sweep_data[%0d]: got %h/%h want 7fff/%h", i, dwd, fwd, CC); else passed++;
      total++; if (ready !== 1'b0) $display("FAIL sweep_ready[%0d]: got %b want 0", i, ready); else passed++;
      total++; if ({pcnt, rcnt} !== '0) $display("FAIL sweep_counts[%0d]: got %0d/%0d want 0/0", i, pcnt, rcnt); else passed++;
      valid = 0;
      clear = poke && i == 3;
    end
    for (int a = 0; a < NPIX; a++) begin
      ref_d[a] = 16'sh7FFF;
      ref_f[a] = CC;
    end
    ref_p = 0;
    ref_r = 0;
    @(negedge clk);
    total++; if ({busy, dwe, fwe, ready} !== 4'b0001) $display("FAIL sweep_end: got busy,dwe,fwe,ready=%b want 0001", {busy, dwe, fwe, ready}); else passed++;
  endtask

  task automatic test_clear(input bit with_valid, input bit poke);
    clear = 1;
    if (with_valid) begin
      valid = 1; hcount = 1; vcount = 1; z = -16'sd5; color = 16'hBEEF;
    end
    sweep(poke);
  endtask

  task automatic do_pixel(input int h, input int v, input int zz, input int c, input int clr);
    int a, n;
    bit inr, ps;
    inr = h < HRES && v < VRES;
    a = v * HRES + h;
    ps = inr && (zz < int'(ref_d[inr ? a : 0]));
    n = inr ? LAT + 3 : 1;
    total++; if (ready !== 1'b1) $display("FAIL pix_ready_before: got %b want 1", ready); else passed++;
    valid = 1; hcount = HW'(h); vcount = VW'(v); z = zz[15:0]; color = c[15:0];
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (!inr) begin
        ref_r = sat(ref_r);
        total++; if ({ready, dwe, fwe, busy} !== 4'b1000) $display("FAIL drop(%0d,%0d): got ready,dwe,fwe,busy=%b want 1000", h, v, {ready, dwe, fwe, busy}); else passed++;
        total++; if (rcnt !== CW'(ref_r) || pcnt !== CW'(ref_p)) $display("FAIL drop_counts: got %0d/%0d want %0d/%0d", pcnt, rcnt, ref_p, ref_r); else passed++;
      end else begin
        if (k == LAT + 2) begin
          if (ps) begin
            ref_d[a] = zz[15:0];
            ref_f[a] = c[15:0];
            ref_p = sat(ref_p);
          end else ref_r = sat(ref_r);
        end
        total++; if ({dwe, fwe} !== {2{k == LAT + 2 && ps}}) $display("FAIL pix_we[c%0d]: got %b want %b", k, {dwe, fwe}, {2{k == LAT + 2 && ps}}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL pix_busy[c%0d]: got %b want 0", k, busy); else passed++;
        total++; if (ready !== (k == n && clr == 0)) $display("FAIL pix_ready[c%0d]: got %b want %b", k, ready, k == n && clr == 0); else passed++;
        if (k == 1 || k == LAT + 2) begin
          total++; if (daddr !== AW'(a)) $display("FAIL pix_daddr[c%0d]: got %0d want %0d", k, daddr, a); else passed++;
        end
        if (k == LAT + 2) begin
          total++; if (dwd !== (ps ? zz[15:0] : 16'h0) || fwd !== (ps ? c[15:0] : 16'h0)) $display("FAIL pix_wdata: got %h/%h want %h/%h", dwd, fwd, ps ? zz[15:0] : 16'h0, ps ? c[15:0] : 16'h0); else passed++;
          if (ps) begin
            total++; if (faddr !== AW'(a)) $display("FAIL pix_faddr: got %0d want %0d", faddr, a); else passed++;
          end
        end
        if (k == n) begin
          total++; if (pcnt !== CW'(ref_p) || rcnt !== CW'(ref_r)) $display("FAIL pix_counts: got %0d/%0d want %0d/%0d", pcnt, rcnt, ref_p, ref_r); else passed++;
        end
      end
      if (k == 1) valid = 0;
      if (clr != 0 && k == clr) clear = 1;
      if (clr != 0 && k == clr + 1) clear = 0;
    end
    if (clr != 0) sweep(0);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if ({busy, dwe, fwe, daddr, faddr, dwd, fwd, pcnt, rcnt, ready} !== '0) $display("FAIL reset_outputs: got nonzero outputs during reset"); else passed++;
    rst = 0;
    #1;
    total++; if (ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", ready); else passed++;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_pixel(1, 1, 100, 16'hABCD, 0);
    do_pixel(1, 1, 200, 16'h0F0F, 0);
    do_pixel(1, 1, 100, 16'h0F0F, 0);
    do_pixel(5, 0, 1, 16'h1111, 0);
    do_pixel(0, 3, 1, 16'h1111, 0);
    do_pixel(2, 2, -3, 16'h2222, 0);
    do_pixel(2, 2, -3, 16'h3333, 0);
    do_pixel(4, 2, -32768, 16'h4444, 0);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < SAT + 3; i++) do_pixel(7, 3, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++)
      do_pixel($urandom_range(0, 6), $urandom_range(0, 3), int'($urandom_range(0, 16)) - 8, $urandom_range(0, 65535), 0);
    for (int a = 0; a < NPIX; a++) begin
      total++; if (dmem[a] !== ref_d[a] || fmem[a] !== ref_f[a]) $display("FAIL mem[%0d]: got %h/%h want %h/%h", a, dmem[a], fmem[a], ref_d[a], ref_f[a]); else passed++;
    end
  endtask

  task automatic test_reset_mid(input bit in_clear);
    if (in_clear) begin
      clear = 1;
      @(negedge clk);
      clear = 0;
      repeat (3) @(negedge clk);
    end else begin
      valid = 1; hcount = 2; vcount = 1; z = -16'sd100; color = 16'h7777;
      @(posedge clk);
      @(negedge clk);
      valid = 0;
      @(negedge clk);
    end
    #1 rst = 1;
    #1;
    total++; if ({busy, dwe, fwe, daddr, faddr, dwd, fwd, pcnt, rcnt, ready} !== '0) $display("FAIL reset_mid%0d_outputs: got nonzero outputs after reset", in_clear); else passed++;
    repeat (2) begin
      @(negedge clk);
      total++; if ({dwe, fwe, busy} !== 3'b000) $display("FAIL reset_mid%0d_quiet: got %b want 000", in_clear, {dwe, fwe, busy}); else passed++;
    end
    rst = 0;
    ref_p = 0;
    ref_r = 0;
    @(negedge clk);
    total++; if ({ready, dwe, fwe, busy} !== 4'b1000) $display("FAIL reset_mid%0d_release: got %b want 1000", in_clear, {ready, dwe, fwe, busy}); else passed++;
  endtask

  initial begin
    #200000 $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < NPIX; a++) begin
      dmem[a] = 16'($urandom);
      fmem[a] = 16'($urandom);
    end
    for (int i = 0; i < LAT; i++) dpipe[i] = 0;
    test_reset;
    test_clear(0, 0);
    test_basic;
    test_clear(1, 0);
    do_pixel(3, 1, 7, 16'h5555, 2);
    do_pixel(4, 2, -100, 16'h1111, LAT + 2);
    test_clear(0, 1);
    test_saturation;
    test_back_to_back;
    test_reset_mid(0);
    do_pixel(2, 1, 5, 16'h6666, 0);
    test_reset_mid(1);
    test_clear(0, 0);
    do_pixel(1, 1, 100, 16'hABCD, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/depth_test_writer.md
Name: depth_test_writer

Overview:
- Consumer end of the rasterizer pixel stream: accepts one pixel per valid/ready handshake (hcount, vcount, z, colour).
- Performs a read-compare-write depth test against an external depth BRAM and writes passing pixels to the framebuffer BRAM.
- Provides a full-buffer clear sweep and pass/reject statistics.
- Sits between the rasterizer/shader and the framebuffer memories.

Parameters:
- FWIDTH, 16, depth word width, signed.
- COLOR_W, 16, framebuffer pixel width.
- FB_HRES, 320, framebuffer width in pixels.
- FB_VRES, 180, framebuffer height in pixels.
- RD_LAT, 2, depth BRAM read latency in cycles (>=1).
- CLEAR_COLOR, 0, colour written during clear.
- CNT_W, 24, statistics counter width.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- valid_in  input  1  pixel valid from upstream
- ready_out  output  1  block can accept a pixel this cycle
- hcount_in  input  $clog2(FB_HRES)  pixel column
- vcount_in  input  $clog2(FB_VRES)  pixel row
- z_in  input  FWIDTH signed  pixel depth; smaller is closer
- color_in  input  COLOR_W  pixel colour
- clear_in  input  1  request full-buffer clear (pulse)
- clear_busy_out  output  1  clear sweep in progress
- depth_addr_out  output  ADDR_W  depth BRAM address; ADDR_W = $clog2(FB_HRES*FB_VRES)
- depth_rd_data_in  input  FWIDTH  depth BRAM read data
- depth_wr_en_out  output  1  depth BRAM write enable
- depth_wr_data_out  output  FWIDTH  depth BRAM write data
- fb_addr_out  output  ADDR_W  framebuffer address
- fb_wr_en_out  output  1  framebuffer write enable
- fb_wr_data_out  output  COLOR_W  framebuffer write data
- pass_count_out  output  CNT_W  pixels written since reset or last clear
- reject_count_out  output  CNT_W  pixels rejected since reset or last clear

Behaviour:
- Reset: asynchronous, active-high.
  - All registered outputs go to 0 immediately; state goes to IDLE; pending clear is dropped.
  - ready_out is 0 while rst_in is high and 1 in the first cycle after deassertion.
  - A reset mid-pixel or mid-clear abandons the operation; no write enable may be asserted after reset asserts.
- States: IDLE, READ, WAIT, WRITE, CLEAR.
- ready_out = (state == IDLE) and no clear pending and not rst_in.
- Accept: valid_in && ready_out at cycle 0 latches the inputs.
  - addr = vcount*FB_HRES + hcount.
  - Out-of-range coordinates (hcount >= FB_HRES or vcount >= FB_VRES): pixel is dropped, reject_count increments, no memory access, state stays IDLE.
- Cycle 1 (READ): depth_addr_out = addr, held until WRITE completes. WAIT counts RD_LAT-1 further cycles.
- Cycle 1+RD_LAT: depth_rd_data_in is sampled and compared signed; pass iff z_in < stored, so an equal depth rejects.
- Cycle 2+RD_LAT (WRITE):
  - Pass: depth_wr_en_out = 1, depth_wr_data_out = z; fb_wr_en_out = 1, fb_addr_out = addr, fb_wr_data_out = colour; pass_count increments.
  - Fail: no write enables; reject_count increments.
- Cycle 3+RD_LAT: state returns to IDLE. Pixel interval is RD_LAT+3 cycles.
- Write enables are single-cycle pulses. Write data is 0 when enable is low.
- Clear:
  - clear_in seen in IDLE, or latched as pending during a pixel operation, enters CLEAR after any current pixel finishes.
  - clear_in has priority over a simultaneous valid_in; that pixel is not accepted.
  - CLEAR writes one address per cycle, 0 to FB_HRES*FB_VRES-1. Depth data = max positive signed (0 followed by ones); fb data = CLEAR_COLOR; both enables high each cycle.
  - clear_busy_out is high for exactly FB_HRES*FB_VRES cycles. Both counters zero on CLEAR entry.
  - clear_in during CLEAR is ignored. Return to IDLE after the last address.
- Counters saturate at all-ones; no wrap.

Test Plan:
- FB_HRES=4, FB_VRES=2, RD_LAT=2; pulse clear_in -> 8 consecutive cycles of both write enables at addresses 0..7, depth data 0x7FFF, clear_busy_out high 8 cycles, ready_out low throughout.
- After clear, pixel (h=1, v=1, z=100, colour=0xABCD) -> depth_addr_out=5 at cycle 1; at cycle 4 writes depth 100 and colour 0xABCD at address 5; pass_count=1; ready_out high at cycle 5.
- Repeat (1,1) with z=200, then z=100 -> no write enables either time; reject_count=2.
- Pixel h=4, v=0 -> dropped in 1 cycle, reject_count+1, no memory activity, ready_out stays high.
- clear_in and valid_in asserted together in IDLE -> pixel not accepted, clear sweep runs. clear_in during WAIT -> pixel write completes, then sweep starts and counters zero.
- Assert rst_in during WAIT and during CLEAR -> all outputs 0 immediately, no further write pulses, ready_out=1 one cycle after release.
